// File: rtl/vram_cpu_writer.sv
// vram_cpu_writer: CPU-side access to the shared video RAM.
// CPU writes go into a small FIFO. Each buffered write is committed only in a
// cycle where the display engine is not using the single VRAM port.
// CPU reads keep their order relative to earlier buffered writes.
// The video mode byte is double-buffered and becomes active at frame start.
module vram_cpu_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 13
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              cpu_wr_req,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [7:0]        cpu_wr_data,
    output logic              cpu_wr_ready,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic              cpu_rd_busy,
    output logic [7:0]        cpu_rd_data,
    output logic              cpu_rd_valid,
    input  logic              mode_wr,
    input  logic [7:0]        mode_data,
    input  logic              frame_start,
    output logic              ag,
    output logic [2:0]        gm,
    output logic              css,
    input  logic              disp_rd,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT} state_t;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     rd_ahead;    // buffered writes that are older than the pending read
    logic [ADDR_W-1:0] rd_addr;
    state_t            state;
    logic              shadow_ag;
    logic              shadow_css;
    logic [2:0]        shadow_gm;
    logic              push;
    logic              pop;
    logic              rd_accept;
    logic              rd_go;
    logic              unused_mode_bits;

    // Mode byte bits [2:0] do not hold any mode state.
    assign unused_mode_bits = ^mode_data[2:0];

    assign cpu_wr_ready = (count != CW'(FIFO_DEPTH));
    assign push         = cpu_wr_req && cpu_wr_ready;
    assign pop          = (state == WRITE) && !disp_rd;
    assign rd_accept    = cpu_rd_req && !cpu_rd_busy;
    // A read may start when no older write is still buffered.
    // The second term lets a new read on an idle, empty buffer go straight to issue.
    // A write pushed in the same cycle as the read counts as older than the read.
    assign rd_go        = (cpu_rd_busy && rd_ahead == '0) ||
                          (rd_accept && count == '0 && !push);

    // FIFO payload and read address storage (data path, no reset)
    always_ff @(posedge pixel_clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_wr_addr;
            fifo_data[wr_ptr] <= cpu_wr_data;
        end
        if (rd_accept) begin
            rd_addr <= cpu_rd_addr;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Port arbitration FSM together with read tracking and read result registers
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rd_ahead     <= '0;
            cpu_rd_busy  <= 1'b0;
            cpu_rd_data  <= 8'h00;
            cpu_rd_valid <= 1'b0;
        end else begin
            cpu_rd_valid <= 1'b0;
            if (rd_accept) begin
                cpu_rd_busy <= 1'b1;
                rd_ahead    <= count + CW'(push) - CW'(pop);
            end else if (pop && rd_ahead != '0) begin
                rd_ahead <= rd_ahead - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rd_go)              state <= RD_ISSUE;
                    else if (count != '0)   state <= WRITE;
                end
                WRITE: begin
                    if (!disp_rd) state <= IDLE;
                end
                RD_ISSUE: begin
                    if (!disp_rd) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    cpu_rd_data  <= vram_rdata;
                    cpu_rd_valid <= 1'b1;
                    cpu_rd_busy  <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mode latch: shadow loads on mode_wr, active copies the old shadow at frame start
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            shadow_ag  <= 1'b0;
            shadow_css <= 1'b0;
            shadow_gm  <= 3'b000;
            ag         <= 1'b0;
            css        <= 1'b0;
            gm         <= 3'b000;
        end else begin
            if (mode_wr) begin
                shadow_ag  <= mode_data[3];
                shadow_css <= mode_data[4];
                shadow_gm  <= mode_data[7:5];
            end
            if (frame_start) begin
                ag  <= shadow_ag;
                css <= shadow_css;
                gm  <= shadow_gm;
            end
        end
    end

    // VRAM port mux: the display always wins the port
    always_comb begin
        vram_addr = rd_addr;
        vram_we   = 1'b0;
        if (disp_rd) begin
            vram_addr = disp_addr;
        end else if (state == WRITE) begin
            vram_addr = fifo_addr[rd_ptr];
            vram_we   = 1'b1;
        end
    end

    assign vram_wdata = fifo_data[rd_ptr];

endmodule

// File: tb/tb_vram_cpu_writer.sv
// tb_vram_cpu_writer: directed and randomized bench for vram_cpu_writer with a VRAM model.
module tb_vram_cpu_writer;

    localparam int AW = 13;

    logic          pixel_clock = 1'b0;
    logic          reset       = 1'b0;
    logic          cpu_wr_req  = 1'b0;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [7:0]    cpu_wr_data = '0;
    logic          cpu_wr_ready;
    logic          cpu_rd_req  = 1'b0;
    logic [AW-1:0] cpu_rd_addr = '0;
    logic          cpu_rd_busy;
    logic [7:0]    cpu_rd_data;
    logic          cpu_rd_valid;
    logic          mode_wr     = 1'b0;
    logic [7:0]    mode_data   = '0;
    logic          frame_start = 1'b0;
    logic          ag;
    logic [2:0]    gm;
    logic          css;
    logic          disp_rd     = 1'b0;
    logic [AW-1:0] disp_addr   = '0;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [7:0]    vram_wdata;
    logic [7:0]    vram_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic       vclr = 1'b1;
    logic [7:0] vmem    [8192];
    logic [7:0] ref_mem [8192];
    logic [20:0] wq[$];
    logic [7:0]  rq[$];

    vram_cpu_writer #(.FIFO_DEPTH(4), .ADDR_W(AW)) dut (
        .pixel_clock(pixel_clock), .reset(reset),
        .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_wr_ready(cpu_wr_ready),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_busy(cpu_rd_busy),
        .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid),
        .mode_wr(mode_wr), .mode_data(mode_data), .frame_start(frame_start),
        .ag(ag), .gm(gm), .css(css),
        .disp_rd(disp_rd), .disp_addr(disp_addr),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata)
    );

    always #5 pixel_clock = ~pixel_clock;

    always @(posedge pixel_clock) cyc <= cyc + 1;

    // Single-port synchronous VRAM: read data appears the cycle after the address
    always @(posedge pixel_clock) begin
        if (vclr) begin
            for (int i = 0; i < 8192; i++) vmem[i] <= 8'h00;
        end else if (vram_we) begin
            vmem[vram_addr] <= vram_wdata;
        end
        vram_rdata <= vmem[vram_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc_start();
        @(posedge pixel_clock);
        #2;
    endtask

    task automatic idle_inputs();
        cpu_wr_req  = 1'b0;
        cpu_rd_req  = 1'b0;
        mode_wr     = 1'b0;
        frame_start = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(8176, 8191));
        return AW'($urandom_range(0, 15));
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        disp_rd = 1'b0;
        repeat (2) @(posedge pixel_clock);
        vclr = 1'b0;
        @(negedge pixel_clock);
        n_tests++;
        if ({cpu_wr_ready, cpu_rd_busy, cpu_rd_valid} !== 3'b100) begin
            n_fail++; $display("FAIL reset_flags: got rdy/busy/vld=%b want 100", {cpu_wr_ready, cpu_rd_busy, cpu_rd_valid});
        end
        n_tests++;
        if (cpu_rd_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_rd_data: got %h want 00", cpu_rd_data);
        end
        n_tests++;
        if ({ag, gm, css} !== 5'b0) begin
            n_fail++; $display("FAIL reset_mode: got ag/gm/css=%b want 00000", {ag, gm, css});
        end
        n_tests++;
        if (vram_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_we: got %b want 0", vram_we);
        end
        cyc_start();
        reset = 1'b1;
    endtask

    task automatic test_write_latency();
        for (int t = 0; t < 4; t++) begin
            cyc_start();
            idle_inputs();
            disp_rd = 1'b0;
            if (t == 0) begin
                cpu_wr_req = 1'b1; cpu_wr_addr = 13'h0010; cpu_wr_data = 8'hA5;
            end
            @(negedge pixel_clock);
            n_tests++;
            if (vram_we !== (t == 2)) begin
                n_fail++; $display("FAIL wr_lat_we_c%0d: got %b want %b", t, vram_we, (t == 2));
            end
            if (t == 2) begin
                n_tests++;
                if ({vram_addr, vram_wdata} !== {13'h0010, 8'hA5}) begin
                    n_fail++; $display("FAIL wr_lat_payload: got %h/%h want 0010/a5", vram_addr, vram_wdata);
                end
            end
            n_tests++;
            if (cpu_wr_ready !== 1'b1) begin
                n_fail++; $display("FAIL wr_lat_ready_c%0d: got %b want 1", t, cpu_wr_ready);
            end
        end
    endtask

    task automatic test_read_latency();
        for (int t = 0; t < 5; t++) begin
            cyc_start();
            idle_inputs();
            disp_rd = 1'b0;
            if (t == 0) begin
                cpu_rd_req = 1'b1; cpu_rd_addr = 13'h0010;
            end
            @(negedge pixel_clock);
            n_tests++;
            if ({cpu_rd_valid, cpu_rd_busy} !== {(t == 3), (t == 1 || t == 2)}) begin
                n_fail++; $display("FAIL rd_lat_c%0d: got vld/busy=%b%b want %b%b", t, cpu_rd_valid, cpu_rd_busy, (t == 3), (t == 1 || t == 2));
            end
            if (t >= 3) begin
                n_tests++;
                if (cpu_rd_data !== 8'hA5) begin
                    n_fail++; $display("FAIL rd_lat_data_c%0d: got %h want a5", t, cpu_rd_data);
                end
            end
        end
    endtask

    task automatic test_read_after_write();
        int we_cyc = -1;
        int val_cyc = -1;
        logic [7:0] got = 8'h00;
        for (int t = 0; t < 25; t++) begin
            cyc_start();
            idle_inputs();
            disp_rd = 1'b0;
            if (t == 0) begin
                cpu_wr_req = 1'b1; cpu_wr_addr = 13'h1FFF; cpu_wr_data = 8'h3C;
            end
            if (t == 1) begin
                cpu_rd_req = 1'b1; cpu_rd_addr = 13'h1FFF;
            end
            @(negedge pixel_clock);
            if (vram_we && vram_addr == 13'h1FFF && we_cyc < 0) we_cyc = t;
            if (cpu_rd_valid) begin
                val_cyc = t; got = cpu_rd_data;
                break;
            end
        end
        n_tests++;
        if (val_cyc < 0) begin
            n_fail++; $display("FAIL raw_valid: got no cpu_rd_valid in 25 cycles want one pulse");
        end
        n_tests++;
        if (got !== 8'h3C) begin
            n_fail++; $display("FAIL raw_data: got %h want 3c", got);
        end
        n_tests++;
        if (!(we_cyc >= 0 && val_cyc > we_cyc)) begin
            n_fail++; $display("FAIL raw_order: got commit cycle %0d valid cycle %0d want commit before valid", we_cyc, val_cyc);
        end
    endtask

    task automatic test_fifo_full();
        logic [20:0] exp_w [4];
        logic [20:0] got_w [$];
        int nwe = 0;
        int badmux = 0;
        for (int i = 0; i < 4; i++) exp_w[i] = {AW'(13'h0200 + i), 8'(8'h50 + i)};
        for (int t = 0; t < 20; t++) begin
            cyc_start();
            idle_inputs();
            disp_rd   = 1'b1;
            disp_addr = AW'($urandom);
            if (t < 4) begin
                cpu_wr_req = 1'b1; cpu_wr_addr = exp_w[t][20:8]; cpu_wr_data = exp_w[t][7:0];
            end
            @(negedge pixel_clock);
            if (vram_we) nwe++;
            if (vram_addr !== disp_addr) badmux++;
            if (t == 3 || t == 4) begin
                n_tests++;
                if (cpu_wr_ready !== (t == 3)) begin
                    n_fail++; $display("FAIL full_ready_c%0d: got %b want %b", t, cpu_wr_ready, (t == 3));
                end
            end
        end
        n_tests++;
        if (nwe != 0) begin
            n_fail++; $display("FAIL full_no_we: got %0d writes want 0", nwe);
        end
        n_tests++;
        if (badmux != 0) begin
            n_fail++; $display("FAIL full_disp_mux: got %0d cycles with wrong address want 0", badmux);
        end
        for (int t = 0; t < 30; t++) begin
            cyc_start();
            idle_inputs();
            disp_rd = 1'b0;
            @(negedge pixel_clock);
            if (vram_we) got_w.push_back({vram_addr, vram_wdata});
        end
        n_tests++;
        if (got_w.size() != 4) begin
            n_fail++; $display("FAIL full_commit_count: got %0d want 4", got_w.size());
        end
        for (int i = 0; i < 4 && i < got_w.size(); i++) begin
            n_tests++;
            if (got_w[i] !== exp_w[i]) begin
                n_fail++; $display("FAIL full_commit_%0d: got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
        n_tests++;
        if (cpu_wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_ready_back: got %b want 1", cpu_wr_ready);
        end
    endtask

    task automatic test_disp_toggle();
        logic [AW-1:0] ad [8];
        logic [7:0]    dd [8];
        int k = 0;
        int ncommit = 0;
        int viol = 0;
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            ad[i] = AW'(13'h0100 + i * 3);
            dd[i] = 8'($urandom);
        end
        for (int t = 0; t < 80; t++) begin
            cyc_start();
            idle_inputs();
            disp_rd = (t % 2 == 0);
            if (k < 8 && cpu_wr_ready) begin
                cpu_wr_req = 1'b1; cpu_wr_addr = ad[k]; cpu_wr_data = dd[k];
                k++;
            end
            @(negedge pixel_clock);
            if (vram_we) begin
                ncommit++;
                if (disp_rd) viol++;
            end
            if (ncommit == 8) break;
        end
        cyc_start();
        idle_inputs();
        disp_rd = 1'b0;
        for (int i = 0; i < 8; i++) if (vmem[ad[i]] !== dd[i]) bad++;
        n_tests++;
        if (ncommit != 8) begin
            n_fail++; $display("FAIL toggle_commits: got %0d want 8", ncommit);
        end
        n_tests++;
        if (viol != 0) begin
            n_fail++; $display("FAIL toggle_we_during_disp: got %0d want 0", viol);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL toggle_vram_contents: got %0d wrong bytes want 0", bad);
        end
    endtask

    task automatic test_mode();
        // step: mode_wr, mode_data, frame_start, check flag, expected {ag,css,gm}
        logic [7:0] mdat [8] = '{8'h18, 8'h00, 8'h00, 8'h00, 8'h08, 8'hE0, 8'h00, 8'h00};
        logic       mw   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       fs   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0] exp_m [8] = '{5'b00000, 5'b00000, 5'b00000, 5'b11000, 5'b11000, 5'b11000, 5'b10000, 5'b00111};
        for (int t = 0; t < 8; t++) begin
            cyc_start();
            idle_inputs();
            disp_rd   = 1'b0;
            mode_wr   = mw[t];
            mode_data = mdat[t];
            frame_start = fs[t];
            @(negedge pixel_clock);
            n_tests++;
            if ({ag, css, gm} !== exp_m[t]) begin
                n_fail++; $display("FAIL mode_step%0d: got ag/css/gm=%b want %b", t, {ag, css, gm}, exp_m[t]);
            end
        end
        // step 7 wrote 0x00 to the shadow; confirm active holds gm=7 until the next frame start
        cyc_start();
        idle_inputs();
        @(negedge pixel_clock);
        n_tests++;
        if ({ag, css, gm} !== 5'b00111) begin
            n_fail++; $display("FAIL mode_hold: got ag/css/gm=%b want 00111", {ag, css, gm});
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [20:0]   e;
        logic [7:0]    er;
        int mis = 0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = vmem[i];
        wq.delete();
        rq.delete();
        for (int t = 0; t < 1200; t++) begin
            cyc_start();
            idle_inputs();
            disp_rd   = ($urandom_range(0, 2) == 0);
            disp_addr = AW'($urandom);
            if (t < 500) begin
                if (cpu_wr_ready && $urandom_range(0, 1) == 1) begin
                    a = rand_addr(); d = 8'($urandom);
                    cpu_wr_req = 1'b1; cpu_wr_addr = a; cpu_wr_data = d;
                    ref_mem[a] = d;
                    wq.push_back({a, d});
                end
                if (!cpu_rd_busy && $urandom_range(0, 4) == 0) begin
                    a = rand_addr();
                    cpu_rd_req = 1'b1; cpu_rd_addr = a;
                    rq.push_back(ref_mem[a]);
                end
            end
            @(negedge pixel_clock);
            if (vram_we) begin
                n_tests++;
                if (disp_rd) begin
                    n_fail++; $display("FAIL rand_we_during_disp: got vram_we=1 with disp_rd=1 at cycle %0d", cyc);
                end
                n_tests++;
                if (wq.size() == 0) begin
                    n_fail++; $display("FAIL rand_commit: got unexpected write %h/%h want none", vram_addr, vram_wdata);
                end else begin
                    e = wq.pop_front();
                    if ({vram_addr, vram_wdata} !== e) begin
                        n_fail++; $display("FAIL rand_commit: got %h want %h", {vram_addr, vram_wdata}, e);
                    end
                end
            end
            if (cpu_rd_valid) begin
                n_tests++;
                if (rq.size() == 0) begin
                    n_fail++; $display("FAIL rand_read: got unexpected valid data %h want none", cpu_rd_data);
                end else begin
                    er = rq.pop_front();
                    if (cpu_rd_data !== er) begin
                        n_fail++; $display("FAIL rand_read: got %h want %h", cpu_rd_data, er);
                    end
                end
            end
            if (t >= 500 && wq.size() == 0 && rq.size() == 0 && !cpu_rd_busy) break;
        end
        cyc_start();
        idle_inputs();
        disp_rd = 1'b0;
        n_tests++;
        if (wq.size() != 0 || rq.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: got %0d writes %0d reads outstanding want 0", wq.size(), rq.size());
        end
        for (int i = 0; i < 8192; i++) if (vmem[i] !== ref_mem[i]) mis++;
        n_tests++;
        if (mis != 0) begin
            n_fail++; $display("FAIL rand_vram_image: got %0d differing bytes want 0", mis);
        end
    endtask

    task automatic test_reset_midop();
        int nwe = 0;
        int nval = 0;
        for (int t = 0; t < 5; t++) begin
            cyc_start();
            idle_inputs();
            disp_rd = (t == 1 || t == 2);
            if (t == 0) begin
                cpu_rd_req = 1'b1; cpu_rd_addr = 13'h0005;
            end
            if (t >= 1 && t <= 3) begin
                cpu_wr_req = 1'b1; cpu_wr_addr = AW'(13'h0300 + t); cpu_wr_data = 8'(8'hC0 + t);
            end
        end
        #1;
        n_tests++;
        if (cpu_rd_busy !== 1'b1) begin
            n_fail++; $display("FAIL midop_busy_before: got %b want 1", cpu_rd_busy);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({cpu_wr_ready, cpu_rd_busy, cpu_rd_valid, vram_we} !== 4'b1000) begin
            n_fail++; $display("FAIL midop_flags: got rdy/busy/vld/we=%b want 1000", {cpu_wr_ready, cpu_rd_busy, cpu_rd_valid, vram_we});
        end
        n_tests++;
        if ({cpu_rd_data, ag, gm, css} !== 13'h0) begin
            n_fail++; $display("FAIL midop_regs: got rd_data=%h ag/gm/css=%b want 00/00000", cpu_rd_data, {ag, gm, css});
        end
        @(posedge pixel_clock);
        @(negedge pixel_clock);
        n_tests++;
        if (vram_we !== 1'b0) begin
            n_fail++; $display("FAIL midop_we_in_reset: got %b want 0", vram_we);
        end
        cyc_start();
        reset = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge pixel_clock);
            if (vram_we) nwe++;
            if (cpu_rd_valid) nval++;
            cyc_start();
        end
        n_tests++;
        if (nwe != 0 || nval != 0) begin
            n_fail++; $display("FAIL midop_after_release: got %0d writes %0d read pulses want 0/0", nwe, nval);
        end
        n_tests++;
        if (cpu_wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL midop_ready: got %b want 1", cpu_wr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_read_latency();
        test_read_after_write();
        test_fifo_full();
        test_disp_toggle();
        test_mode();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
